keypad_emu: RTL and testbench



---
 rtl/keypad_emu.sv | 162 ++++++++++++++++
 tb/tb_keypad_emu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emu.sv
// keypad_emu: 4x3 keypad matrix emulator with LFSR contact bounce.
// Ports: clk, rst_n, col[2:0] (in, active low), press_req, release_req,
//        key_code[3:0] (in); row[3:0] (out, active low), busy, pressed,
//        code_err (out).
module keypad_emu #(
    parameter int unsigned BOUNCE_CYC = 500,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] col,
    input  logic       press_req,
    input  logic       release_req,
    input  logic [3:0] key_code,
    output logic [3:0] row,
    output logic       busy,
    output logic       pressed,
    output logic       code_err
);

    localparam logic [15:0] RELOAD = 16'(BOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] lfsr;
    logic        contact;
    logic        pending;
    logic [1:0]  r_key;
    logic [1:0]  c_key;

    logic        fb;
    logic        bounce_tgl;
    logic        key_ok;
    logic [1:0]  kr;
    logic [1:0]  kc;
    logic        col_hit;
    logic [3:0]  row_nxt;

    assign fb         = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign bounce_tgl = (lfsr[3:0] == 4'd0);

    // key_code -> (row, column) = (code/3, code%3)
    always_comb begin
        key_ok = 1'b1;
        kr     = 2'd0;
        kc     = 2'd0;
        unique case (key_code)
            4'd0:  begin kr = 2'd0; kc = 2'd0; end
            4'd1:  begin kr = 2'd0; kc = 2'd1; end
            4'd2:  begin kr = 2'd0; kc = 2'd2; end
            4'd3:  begin kr = 2'd1; kc = 2'd0; end
            4'd4:  begin kr = 2'd1; kc = 2'd1; end
            4'd5:  begin kr = 2'd1; kc = 2'd2; end
            4'd6:  begin kr = 2'd2; kc = 2'd0; end
            4'd7:  begin kr = 2'd2; kc = 2'd1; end
            4'd8:  begin kr = 2'd2; kc = 2'd2; end
            4'd9:  begin kr = 2'd3; kc = 2'd0; end
            4'd10: begin kr = 2'd3; kc = 2'd1; end
            4'd11: begin kr = 2'd3; kc = 2'd2; end
            default: key_ok = 1'b0;
        endcase
    end

    // Only the latched column matters; other strobes are don't-care.
    always_comb begin
        col_hit = 1'b0;
        unique case (c_key)
            2'd0:    col_hit = ~col[0];
            2'd1:    col_hit = ~col[1];
            2'd2:    col_hit = ~col[2];
            default: col_hit = 1'b0;
        endcase
    end

    always_comb begin
        row_nxt = 4'b1111;
        if (contact && col_hit)
            row_nxt[r_key] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            lfsr     <= SEED;
            contact  <= 1'b0;
            pending  <= 1'b0;
            r_key    <= 2'd0;
            c_key    <= 2'd0;
            row      <= 4'b1111;
            busy     <= 1'b0;
            pressed  <= 1'b0;
            code_err <= 1'b0;
        end else begin
            lfsr     <= {lfsr[14:0], fb};
            row      <= row_nxt;
            code_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (press_req) begin
                        if (key_ok) begin
                            r_key   <= kr;
                            c_key   <= kc;
                            cnt     <= RELOAD;
                            pending <= 1'b0;
                            busy    <= 1'b1;
                            state   <= BOUNCE_IN;
                        end else begin
                            code_err <= 1'b1;
                        end
                    end
                end
                BOUNCE_IN: begin
                    if (release_req)
                        pending <= 1'b1;
                    if (cnt == 16'd0) begin
                        contact <= 1'b1;
                        if (pending || release_req) begin
                            cnt     <= RELOAD;
                            pending <= 1'b0;
                            state   <= BOUNCE_OUT;
                        end else begin
                            pressed <= 1'b1;
                            state   <= HOLD;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                        if (bounce_tgl)
                            contact <= ~contact;
                    end
                end
                HOLD: begin
                    if (release_req) begin
                        cnt     <= RELOAD;
                        pressed <= 1'b0;
                        state   <= BOUNCE_OUT;
                    end
                end
                BOUNCE_OUT: begin
                    if (cnt == 16'd0) begin
                        contact <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                        if (bounce_tgl)
                            contact <= ~contact;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emu.sv
// tb_keypad_emu: directed bench for keypad_emu, BOUNCE_CYC=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] col;
    logic       press_req;
    logic       release_req;
    logic [3:0] key_code;
    logic [3:0] row;
    logic       busy;
    logic       pressed;
    logic       code_err;

    int checks = 0;
    int errors = 0;

    keypad_emu #(.BOUNCE_CYC(32), .SEED(16'hACE1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col(col),
        .press_req(press_req),
        .release_req(release_req),
        .key_code(key_code),
        .row(row),
        .busy(busy),
        .pressed(pressed),
        .code_err(code_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++)
            @(negedge clk);
    endtask

    // Press a key and step to the first HOLD cycle (33 edges later).
    task automatic press_to_hold(input logic [3:0] k);
        key_code  = k;
        press_req = 1'b1;
        tick(1);
        press_req = 1'b0;
        tick(32);
    endtask

    initial begin
        rst_n       = 1'b0;
        col         = 3'b000;
        press_req   = 1'b0;
        release_req = 1'b0;
        key_code    = 4'd0;

        // Reset
        tick(10);
        chk("rst_row", 16'(row), 16'hF);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_pressed", 16'(pressed), 16'h0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_row", 16'(row), 16'hF);
        chk("idle_busy", 16'(busy), 16'h0);
        chk("idle_pressed", 16'(pressed), 16'h0);

        // Clean press of key 4; a simultaneous release must be ignored
        col         = 3'b101;
        key_code    = 4'd4;
        press_req   = 1'b1;
        release_req = 1'b1;
        tick(1);
        press_req   = 1'b0;
        release_req = 1'b0;
        chk("press_busy", 16'(busy), 16'h1);
        chk("press_pressed0", 16'(pressed), 16'h0);
        for (int i = 2; i <= 32; i++) begin
            tick(1);
            chk("bounce_rowset", 16'(row == 4'hF || row == 4'hD), 16'h1);
            chk("bounce_pressed", 16'(pressed), 16'h0);
        end
        tick(1);
        chk("hold_pressed", 16'(pressed), 16'h1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("hold_row", 16'(row), 16'hD);
        end

        // Release with bounce
        release_req = 1'b1;
        tick(1);
        release_req = 1'b0;
        chk("rel_pressed", 16'(pressed), 16'h0);
        chk("rel_busy", 16'(busy), 16'h1);
        tick(31);
        chk("rel_busy_end", 16'(busy), 16'h1);
        tick(1);
        chk("rel_idle_busy", 16'(busy), 16'h0);
        tick(1);
        chk("rel_idle_row", 16'(row), 16'hF);

        // Column gating on key 11
        col = 3'b111;
        press_to_hold(4'd11);
        chk("k11_pressed", 16'(pressed), 16'h1);
        col = 3'b110;
        tick(5);
        chk("gate_c0", 16'(row), 16'hF);
        col = 3'b101;
        tick(5);
        chk("gate_c1", 16'(row), 16'hF);
        col = 3'b011;
        tick(1);
        chk("gate_c2", 16'(row), 16'h7);
        col = 3'b000;
        tick(1);
        chk("gate_all", 16'(row), 16'h7);
        release_req = 1'b1;
        tick(1);
        release_req = 1'b0;
        tick(34);
        chk("k11_idle", 16'(busy), 16'h0);
        chk("k11_row", 16'(row), 16'hF);

        // Early release during BOUNCE_IN
        col       = 3'b101;
        key_code  = 4'd4;
        press_req = 1'b1;
        tick(1);
        press_req = 1'b0;
        tick(4);
        release_req = 1'b1;
        tick(1);
        release_req = 1'b0;
        for (int i = 7; i <= 65; i++) begin
            tick(1);
            chk("early_pressed", 16'(pressed), 16'h0);
            if (i == 64)
                chk("early_busy64", 16'(busy), 16'h1);
            if (i == 65)
                chk("early_busy65", 16'(busy), 16'h0);
        end
        tick(1);
        chk("early_row", 16'(row), 16'hF);

        // Illegal key codes
        key_code  = 4'd12;
        press_req = 1'b1;
        tick(1);
        press_req = 1'b0;
        chk("err12_pulse", 16'(code_err), 16'h1);
        chk("err12_busy", 16'(busy), 16'h0);
        tick(1);
        chk("err12_clear", 16'(code_err), 16'h0);
        chk("err12_busy2", 16'(busy), 16'h0);
        key_code  = 4'd15;
        press_req = 1'b1;
        tick(1);
        press_req = 1'b0;
        chk("err15_pulse", 16'(code_err), 16'h1);
        tick(1);
        chk("err15_clear", 16'(code_err), 16'h0);

        // Overlapping press during HOLD of key 4
        press_to_hold(4'd4);
        tick(2);
        chk("ovl_row_pre", 16'(row), 16'hD);
        key_code  = 4'd7;
        press_req = 1'b1;
        tick(1);
        press_req = 1'b0;
        chk("ovl_err", 16'(code_err), 16'h0);
        chk("ovl_pressed", 16'(pressed), 16'h1);
        tick(2);
        chk("ovl_row", 16'(row), 16'hD);

        // Asynchronous reset mid-hold
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_row", 16'(row), 16'hF);
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_pressed", 16'(pressed), 16'h0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("post_rst_busy", 16'(busy), 16'h0);
            chk("post_rst_row", 16'(row), 16'hF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
